trace_nop_event_collector: RTL and testbench

- Consumes per-core instruction trace streams (valid, insn, r3) from the compute tiles of a multi-tile system simulation.
- Decodes the simulation-control l.nop instructions (exit, report, putc) into tagged events.
- Arbitrates those events round-robin onto one valid/ready stream for the host-side monitor.
- Aggregates per-core termination into a global all_terminated/exit status, with a watchdog timeout.

---
 rtl/trace_nop_event_collector.sv | 204 ++++++++++++++++++++
 tb/tb_trace_nop_event_collector.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_nop_event_collector.sv
// Collects simulation-control l.nop events (exit/report/putc) from per-core trace streams,
// arbitrates them round-robin onto one valid/ready stream and tracks global termination.
module trace_nop_event_collector #(
    parameter int unsigned NUM_CORES      = 36,
    parameter int unsigned CORE_ID_W      = 7,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CORES-1:0]    trace_valid,
    input  logic [32*NUM_CORES-1:0] trace_insn,
    input  logic [32*NUM_CORES-1:0] trace_r3,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [CORE_ID_W-1:0]    evt_core,
    output logic [1:0]              evt_type,
    output logic [31:0]             evt_data,
    output logic [NUM_CORES-1:0]    terminated,
    output logic                    all_terminated,
    output logic [31:0]             exit_code,
    output logic [NUM_CORES-1:0]    overflow,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        EVT_EXIT   = 2'd0,
        EVT_REPORT = 2'd1,
        EVT_PUTC   = 2'd2
    } evt_type_e;

    logic [NUM_CORES-1:0] r_full;
    evt_type_e            r_slot_type [NUM_CORES];
    logic [31:0]          r_slot_data [NUM_CORES];
    logic [NUM_CORES-1:0] r_overflow;
    logic [CORE_ID_W-1:0] r_ptr;
    logic                 r_evt_valid;
    logic [CORE_ID_W-1:0] r_evt_core;
    evt_type_e            r_evt_type;
    logic [31:0]          r_evt_data;
    logic [NUM_CORES-1:0] r_terminated;
    logic                 r_all_term;
    logic [31:0]          r_exit_code;
    logic [31:0]          r_cnt;
    logic                 r_timeout;

    logic [NUM_CORES-1:0] w_hit;
    logic [NUM_CORES-1:0] w_is_exit;
    evt_type_e            w_hit_type [NUM_CORES];
    logic [31:0]          w_exit_or;
    logic                 w_unused_insn;
    logic [NUM_CORES-1:0] w_elig;
    logic [NUM_CORES-1:0] w_drain;
    logic                 w_xfer;
    logic                 w_out_free;
    logic                 w_grant_vld;
    logic [CORE_ID_W-1:0] w_grant;
    evt_type_e            w_grant_type;
    logic [31:0]          w_grant_data;
    logic [CORE_ID_W-1:0] w_ptr_next;
    logic [31:0]          w_cnt_next;

    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        w_hit         = '0;
        w_is_exit     = '0;
        w_exit_or     = '0;
        w_unused_insn = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_hit_type[i] = EVT_EXIT;
            w_unused_insn = w_unused_insn ^ (^trace_insn[32*i+16 +: 8]);
            if (trace_valid[i] && trace_insn[32*i+24 +: 8] == 8'h15) begin
                case (trace_insn[32*i +: 16])
                    16'h0001: begin
                        w_hit[i]     = 1'b1;
                        w_is_exit[i] = 1'b1;
                        w_exit_or    = w_exit_or | trace_r3[32*i +: 32];
                    end
                    16'h0002: begin
                        w_hit[i]      = 1'b1;
                        w_hit_type[i] = EVT_REPORT;
                    end
                    16'h0004: begin
                        w_hit[i]      = 1'b1;
                        w_hit_type[i] = EVT_PUTC;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_xfer     = r_evt_valid && evt_ready;
    assign w_out_free = !r_evt_valid || evt_ready;

    // The slot currently on the output stays full until accepted, so it is never re-granted.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_drain[i] = w_xfer && (r_evt_core == CORE_ID_W'(i));
            w_elig[i]  = r_full[i] && !(r_evt_valid && (r_evt_core == CORE_ID_W'(i)));
        end
    end

    // Round-robin: first eligible slot at or above the pointer, else first eligible below it.
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant      = '0;
        w_grant_type = EVT_EXIT;
        w_grant_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_grant_vld && w_elig[i] && (CORE_ID_W'(i) >= r_ptr)) begin
                w_grant_vld  = 1'b1;
                w_grant      = CORE_ID_W'(i);
                w_grant_type = r_slot_type[i];
                w_grant_data = r_slot_data[i];
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_grant_vld && w_elig[i]) begin
                w_grant_vld  = 1'b1;
                w_grant      = CORE_ID_W'(i);
                w_grant_type = r_slot_type[i];
                w_grant_data = r_slot_data[i];
            end
        end
    end

    assign w_ptr_next = (w_grant == CORE_ID_W'(NUM_CORES - 1)) ? '0 : w_grant + CORE_ID_W'(1);
    assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full     <= '0;
            r_overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_hit[i]) begin
                    if (!r_full[i] || w_drain[i]) r_full[i] <= 1'b1;
                    else                          r_overflow[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: slot payload is not reset; it is only ever read while its full bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_hit[i] && (!r_full[i] || w_drain[i])) begin
                r_slot_type[i] <= w_hit_type[i];
                r_slot_data[i] <= trace_r3[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_core  <= '0;
            r_evt_type  <= EVT_EXIT;
            r_evt_data  <= '0;
            r_ptr       <= '0;
        end else if (w_out_free) begin
            r_evt_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_evt_core <= w_grant;
                r_evt_type <= w_grant_type;
                r_evt_data <= w_grant_data;
                r_ptr      <= w_ptr_next;
            end
        end
    end

    // Termination bookkeeping sees every exit, including ones dropped from the slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_terminated <= '0;
            r_all_term   <= 1'b0;
            r_exit_code  <= '0;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_terminated <= r_terminated | w_is_exit;
            r_exit_code  <= r_exit_code | w_exit_or;
            if (&r_terminated) r_all_term <= 1'b1;
            if (!r_all_term) begin
                r_cnt <= w_cnt_next;
                if (TIMEOUT_CYCLES != 32'd0 && w_cnt_next >= TIMEOUT_CYCLES) r_timeout <= 1'b1;
            end
        end
    end

    assign evt_valid      = r_evt_valid;
    assign evt_core       = r_evt_core;
    assign evt_type       = r_evt_type;
    assign evt_data       = r_evt_data;
    assign terminated     = r_terminated;
    assign all_terminated = r_all_term;
    assign exit_code      = r_exit_code;
    assign overflow       = r_overflow;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_trace_nop_event_collector.sv
// Bench for trace_nop_event_collector: a per-cycle reference model checked on every negedge,
// plus directed scenarios with hand-computed expectations.
module tb_trace_nop_event_collector;

    localparam int N   = 36;
    localparam int W   = 7;
    localparam int TMO = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     tv;
    logic [32*N-1:0]  tinsn;
    logic [32*N-1:0]  tr3;
    logic             evt_ready;

    logic             evt_valid;
    logic [W-1:0]     evt_core;
    logic [1:0]       evt_type;
    logic [31:0]      evt_data;
    logic [N-1:0]     terminated;
    logic             all_terminated;
    logic [31:0]      exit_code;
    logic [N-1:0]     overflow;
    logic             timeout;

    logic             d0_evt_valid;
    logic [W-1:0]     d0_evt_core;
    logic [1:0]       d0_evt_type;
    logic [31:0]      d0_evt_data;
    logic [N-1:0]     d0_terminated;
    logic             d0_all_terminated;
    logic [31:0]      d0_exit_code;
    logic [N-1:0]     d0_overflow;
    logic             d0_timeout;

    always #5 clk = ~clk;

    trace_nop_event_collector #(.NUM_CORES(N), .CORE_ID_W(W), .TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .rst_n(rst_n), .trace_valid(tv), .trace_insn(tinsn), .trace_r3(tr3),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_core(evt_core), .evt_type(evt_type),
        .evt_data(evt_data), .terminated(terminated), .all_terminated(all_terminated),
        .exit_code(exit_code), .overflow(overflow), .timeout(timeout)
    );

    trace_nop_event_collector #(.NUM_CORES(N), .CORE_ID_W(W), .TIMEOUT_CYCLES(32'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .trace_valid(tv), .trace_insn(tinsn), .trace_r3(tr3),
        .evt_valid(d0_evt_valid), .evt_ready(evt_ready), .evt_core(d0_evt_core), .evt_type(d0_evt_type),
        .evt_data(d0_evt_data), .terminated(d0_terminated), .all_terminated(d0_all_terminated),
        .exit_code(d0_exit_code), .overflow(d0_overflow), .timeout(d0_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slots as arrays, arbitration expressed as "search after the last granted core".
    logic [N-1:0] m_full;
    logic [1:0]   m_styp [N];
    logic [31:0]  m_sdat [N];
    bit           m_vld;
    int           m_core;
    logic [1:0]   m_typ;
    logic [31:0]  m_dat;
    int           m_last;
    logic [N-1:0] m_term;
    bit           m_allt;
    logic [31:0]  m_exit;
    logic [N-1:0] m_ovf;
    longint       m_cnt;
    bit           m_tmo;

    task automatic model_step();
        bit           xfer;
        bit           pick_ok;
        int           pick;
        logic [1:0]   nt;
        logic [31:0]  nd;
        logic [N-1:0] term_old;
        logic [31:0]  insn;
        if (!rst_n) begin
            m_full = '0; m_vld = 0; m_core = 0; m_typ = 0; m_dat = 0; m_last = N - 1;
            m_term = '0; m_allt = 0; m_exit = 0; m_ovf = '0; m_cnt = 0; m_tmo = 0;
            return;
        end
        xfer     = m_vld && evt_ready;
        pick_ok  = 0;
        pick     = 0;
        nt       = 0;
        nd       = 0;
        term_old = m_term;
        if (!m_vld || evt_ready) begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (!pick_ok && m_full[c] && !(m_vld && c == m_core)) begin
                    pick_ok = 1; pick = c; nt = m_styp[c]; nd = m_sdat[c];
                end
            end
        end
        if (xfer) m_full[m_core] = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit hit = 0;
            logic [1:0] ty = 0;
            insn = tinsn[32*i +: 32];
            if (tv[i] && insn[31:24] == 8'h15) begin
                if (insn[15:0] == 16'h0001) begin hit = 1; ty = 0; end
                if (insn[15:0] == 16'h0002) begin hit = 1; ty = 1; end
                if (insn[15:0] == 16'h0004) begin hit = 1; ty = 2; end
            end
            if (hit) begin
                if (m_full[i]) m_ovf[i] = 1'b1;
                else begin m_full[i] = 1'b1; m_styp[i] = ty; m_sdat[i] = tr3[32*i +: 32]; end
                if (ty == 0) begin m_term[i] = 1'b1; m_exit = m_exit | tr3[32*i +: 32]; end
            end
        end
        if (!m_vld || evt_ready) begin
            m_vld = pick_ok;
            if (pick_ok) begin m_core = pick; m_typ = nt; m_dat = nd; m_last = pick; end
        end
        if (!m_allt) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt >= TMO) m_tmo = 1;
        end
        if (&term_old) m_allt = 1;
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step();
    end

    int          q_core [$];
    logic [31:0] q_data [$];
    int          q_cyc  [$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("evt_valid", 64'(evt_valid), 64'(m_vld));
            check("evt_core", 64'(evt_core), 64'(m_core));
            check("evt_type", 64'(evt_type), 64'(m_typ));
            check("evt_data", 64'(evt_data), 64'(m_dat));
            check("terminated", 64'(terminated), 64'(m_term));
            check("all_terminated", 64'(all_terminated), 64'(m_allt));
            check("exit_code", 64'(exit_code), 64'(m_exit));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("timeout", 64'(timeout), 64'(m_tmo));
            check("dut0_timeout", 64'(d0_timeout), 64'd0);
            check("dut0_all_terminated", 64'(d0_all_terminated), 64'(m_allt));
            if (evt_valid && evt_ready && rst_n) begin
                q_core.push_back(int'(evt_core));
                q_data.push_back(evt_data);
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clr();
        tv = '0; tinsn = '0; tr3 = '0;
    endtask

    task automatic set_evt(input int c, input logic [15:0] code, input logic [31:0] r3);
        tv[c]             = 1'b1;
        tinsn[32*c +: 32] = {8'h15, 8'h00, code};
        tr3[32*c +: 32]   = r3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic q_clear();
        q_core.delete(); q_data.delete(); q_cyc.delete();
    endtask

    initial begin
        rst_n = 1'b0; evt_ready = 1'b0; clr();
        tick();
        do_reset();
        chk_en = 1'b1;

        // Single exit from core 3, alongside instructions that must be ignored.
        evt_ready = 1'b1;
        set_evt(3, 16'h0001, 32'h0);
        set_evt(10, 16'h0003, 32'h5);
        tv[11] = 1'b1; tinsn[32*11 +: 32] = 32'h1400_0001;
        tinsn[32*12 +: 32] = 32'h1500_0001; tr3[32*12 +: 32] = 32'h7;
        tick(); clr();
        at_neg();
        check("t1_no_evt_after_1", 64'(evt_valid), 64'd0);
        check("t1_terminated", 64'(terminated), 64'h8);
        tick();
        at_neg();
        check("t1_evt_valid", 64'(evt_valid), 64'd1);
        check("t1_evt_core", 64'(evt_core), 64'd3);
        check("t1_evt_type", 64'(evt_type), 64'd0);
        check("t1_all_term", 64'(all_terminated), 64'd0);
        repeat (3) tick();

        // All cores exit together; drain order 0..35 on consecutive cycles.
        do_reset();
        q_clear();
        for (int i = 0; i < N; i++) set_evt(i, 16'h0001, (i == 5) ? 32'h2 : 32'h0);
        tick(); clr();
        at_neg();
        check("t2_terminated", 64'(terminated), 64'(36'hF_FFFF_FFFF));
        check("t2_all_term_early", 64'(all_terminated), 64'd0);
        tick();
        at_neg();
        check("t2_all_term", 64'(all_terminated), 64'd1);
        check("t2_exit_code", 64'(exit_code), 64'h2);
        repeat (40) tick();
        check("t2_count", 64'(q_core.size()), 64'd36);
        for (int i = 1; i < q_core.size(); i++) begin
            check("t2_order", 64'(q_core[i]), 64'(i));
            check("t2_back_to_back", 64'(q_cyc[i] - q_cyc[i-1]), 64'd1);
        end

        // Stalled putc 'A', then putc 'B' hits the full slot and is dropped.
        do_reset();
        evt_ready = 1'b0;
        q_clear();
        set_evt(0, 16'h0004, 32'h41);
        tick(); clr();
        tick();
        set_evt(0, 16'h0004, 32'h42);
        tick(); clr();
        at_neg();
        check("t3_overflow", 64'(overflow), 64'h1);
        check("t3_held_data", 64'(evt_data), 64'h41);
        repeat (3) tick();
        evt_ready = 1'b1;
        repeat (5) tick();
        check("t3_one_event", 64'(q_core.size()), 64'd1);
        if (q_data.size() > 0) check("t3_data", 64'(q_data[0]), 64'h41);

        // Cores 1 and 2 report on alternating cycles; output alternates with no drops.
        do_reset();
        q_clear();
        for (int k = 0; k < 24; k++) begin
            clr();
            set_evt((k % 2 == 0) ? 1 : 2, 16'h0002, 32'(k));
            tick();
        end
        clr();
        repeat (5) tick();
        check("t4_overflow", 64'(overflow), 64'd0);
        check("t4_count", 64'(q_core.size()), 64'd24);
        for (int j = 0; j < q_core.size(); j++) begin
            check("t4_alternate", 64'(q_core[j]), (j % 2 == 0) ? 64'd1 : 64'd2);
            check("t4_data", 64'(q_data[j]), 64'(j));
        end

        // Watchdog: 35 of 36 cores exit, timeout fires exactly 100 cycles after reset.
        do_reset();
        for (int i = 0; i < N - 1; i++) set_evt(i, 16'h0001, 32'h0);
        tick(); clr();
        repeat (98) tick();
        at_neg();
        check("t5_timeout_99", 64'(timeout), 64'd0);
        tick();
        at_neg();
        check("t5_timeout_100", 64'(timeout), 64'd1);
        check("t5_dut0_timeout", 64'(d0_timeout), 64'd0);

        do_reset();
        for (int i = 0; i < N; i++) set_evt(i, 16'h0001, 32'h0);
        tick(); clr();
        repeat (150) tick();
        at_neg();
        check("t5b_all_term", 64'(all_terminated), 64'd1);
        check("t5b_timeout", 64'(timeout), 64'd0);

        // Reset mid-stall with three full slots discards everything.
        do_reset();
        evt_ready = 1'b0;
        set_evt(4, 16'h0001, 32'h5);
        set_evt(7, 16'h0004, 32'h37);
        set_evt(9, 16'h0002, 32'h99);
        tick(); clr();
        tick(); tick();
        at_neg();
        check("t6_stall_valid", 64'(evt_valid), 64'd1);
        check("t6_exit_before", 64'(exit_code), 64'h5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        at_neg();
        check("t6_valid", 64'(evt_valid), 64'd0);
        check("t6_core", 64'(evt_core), 64'd0);
        check("t6_data", 64'(evt_data), 64'd0);
        check("t6_terminated", 64'(terminated), 64'd0);
        check("t6_exit_code", 64'(exit_code), 64'd0);
        q_clear();
        evt_ready = 1'b1;
        repeat (10) tick();
        check("t6_no_stale", 64'(q_core.size()), 64'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
